// File: rtl/button_event_pkg.sv
// Shared types for the button event classifier: FSM states and the event-strobe vector.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    W2,
    P2,
    LONG
  } state_e;

  typedef logic [4:0] ev_t;

  localparam int unsigned EV_PRESS   = 0;
  localparam int unsigned EV_RELEASE = 1;
  localparam int unsigned EV_CLICK   = 2;
  localparam int unsigned EV_DBL     = 3;
  localparam int unsigned EV_LONG    = 4;

  function automatic logic is_held(input state_e s);
    return (s == P1) || (s == P2) || (s == LONG);
  endfunction

endpackage

// File: rtl/event_timer.sv
// Saturating cycle counter with synchronous clear and two fixed-threshold compares.
module event_timer #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned LONG_TICKS = 24'h2DC6C0,
  parameter int unsigned DBL_TICKS  = 24'h0F4240
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic long_hit_o,
  output logic dbl_hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign long_hit_o = (cnt_q == CNT_W'(LONG_TICKS - 1));
  assign dbl_hit_o  = (cnt_q == CNT_W'(DBL_TICKS - 1));

endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into registered one-cycle press/release/click/
// double-click/long-press strobes plus a registered held flag.
module button_event_classifier
  import button_event_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned LONG_TICKS = 24'h2DC6C0,
  parameter int unsigned DBL_TICKS  = 24'h0F4240
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic level_in,
  output logic press_strb,
  output logic release_strb,
  output logic click_strb,
  output logic dbl_click_strb,
  output logic long_strb,
  output logic held
);

  logic   lvl_q;
  logic   rise, fall;
  state_e state_q, state_d;
  ev_t    ev_q, ev_d;
  logic   held_q;
  logic   timer_clr, long_hit, dbl_hit;

  assign rise = level_in & ~lvl_q;
  assign fall = ~level_in & lvl_q;

  // The rise edge itself is the first high sample, so the long compare sits one count
  // earlier than the window compare (which starts counting after the release edge).
  event_timer #(
    .CNT_W      (CNT_W),
    .LONG_TICKS (LONG_TICKS - 1),
    .DBL_TICKS  (DBL_TICKS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (timer_clr),
    .long_hit_o (long_hit),
    .dbl_hit_o  (dbl_hit)
  );

  always_comb begin
    state_d = state_q;
    ev_d    = '0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d        = P1;
            ev_d[EV_PRESS] = 1'b1;
          end
        end
        P1: begin
          if (fall) begin
            state_d          = W2;
            ev_d[EV_RELEASE] = 1'b1;
          end else if (long_hit) begin
            state_d       = LONG;
            ev_d[EV_LONG] = 1'b1;
          end
        end
        W2: begin
          // A rise on the expiry edge still counts as the second press.
          if (rise) begin
            state_d        = P2;
            ev_d[EV_PRESS] = 1'b1;
          end else if (dbl_hit) begin
            state_d        = IDLE;
            ev_d[EV_CLICK] = 1'b1;
          end
        end
        P2: begin
          if (fall) begin
            state_d          = IDLE;
            ev_d[EV_DBL]     = 1'b1;
            ev_d[EV_RELEASE] = 1'b1;
          end else if (long_hit) begin
            state_d        = LONG;
            ev_d[EV_CLICK] = 1'b1;
            ev_d[EV_LONG]  = 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state_d          = IDLE;
            ev_d[EV_RELEASE] = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  assign timer_clr = ~enable | (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q   <= 1'b0;
      state_q <= IDLE;
      ev_q    <= '0;
      held_q  <= 1'b0;
    end else begin
      lvl_q   <= level_in;
      state_q <= state_d;
      ev_q    <= ev_d;
      held_q  <= is_held(state_d);
    end
  end

  assign press_strb     = ev_q[EV_PRESS];
  assign release_strb   = ev_q[EV_RELEASE];
  assign click_strb     = ev_q[EV_CLICK];
  assign dbl_click_strb = ev_q[EV_DBL];
  assign long_strb      = ev_q[EV_LONG];
  assign held           = held_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with LONG_TICKS=100, DBL_TICKS=40.
module tb_button_event_classifier;

  logic clk = 1'b0;
  logic reset, enable, level_in;
  logic press_strb, release_strb, click_strb, dbl_click_strb, long_strb, held;

  button_event_classifier #(
    .CNT_W      (8),
    .LONG_TICKS (100),
    .DBL_TICKS  (40)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .level_in       (level_in),
    .press_strb     (press_strb),
    .release_strb   (release_strb),
    .click_strb     (click_strb),
    .dbl_click_strb (dbl_click_strb),
    .long_strb      (long_strb),
    .held           (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_click = 0, n_dbl = 0, n_long = 0;
  int t_press = 0, t_rel = 0, t_click = 0, t_dbl = 0, t_long = 0;
  int b_press, b_rel, b_click, b_dbl, b_long;
  int total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts and edge index of the most recent occurrence.
  always @(negedge clk) begin
    if (press_strb)     begin n_press++; t_press = cyc; end
    if (release_strb)   begin n_rel++;   t_rel   = cyc; end
    if (click_strb)     begin n_click++; t_click = cyc; end
    if (dbl_click_strb) begin n_dbl++;   t_dbl   = cyc; end
    if (long_strb)      begin n_long++;  t_long  = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    b_press = n_press; b_rel = n_rel; b_click = n_click; b_dbl = n_dbl; b_long = n_long;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return int'({press_strb, release_strb, click_strb, dbl_click_strb, long_strb, held});
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; level_in = 1'b0;
    step(3);
    check("reset_outs", outs(), 0);
    reset = 1'b0; enable = 1'b1;
    step(5);
    check("idle_outs", outs(), 0);

    // Single click
    snap();
    level_in = 1'b1; step(20); level_in = 1'b0; step(60);
    check("s1_press_cnt", n_press - b_press, 1);
    check("s1_rel_cnt", n_rel - b_rel, 1);
    check("s1_press_to_rel", t_rel - t_press, 20);
    check("s1_click_cnt", n_click - b_click, 1);
    check("s1_rel_to_click", t_click - t_rel, 40);
    check("s1_dbl_cnt", n_dbl - b_dbl, 0);
    check("s1_long_cnt", n_long - b_long, 0);

    // Double click
    snap();
    level_in = 1'b1; step(20); level_in = 1'b0; step(10);
    level_in = 1'b1; step(20); level_in = 1'b0; step(60);
    check("s2_press_cnt", n_press - b_press, 2);
    check("s2_rel_cnt", n_rel - b_rel, 2);
    check("s2_dbl_cnt", n_dbl - b_dbl, 1);
    check("s2_dbl_eq_rel", t_dbl, t_rel);
    check("s2_click_cnt", n_click - b_click, 0);
    check("s2_long_cnt", n_long - b_long, 0);

    // Long press
    snap();
    level_in = 1'b1; step(2);
    check("s3_held_early", int'(held), 1);
    step(148);
    check("s3_held_late", int'(held), 1);
    check("s3_long_cnt", n_long - b_long, 1);
    check("s3_press_to_long", t_long - t_press, 99);
    level_in = 1'b0; step(60);
    check("s3_rel_cnt", n_rel - b_rel, 1);
    check("s3_press_to_rel", t_rel - t_press, 150);
    check("s3_click_cnt", n_click - b_click, 0);
    check("s3_held_after", int'(held), 0);

    // Second rise exactly on window expiry: double click wins
    snap();
    level_in = 1'b1; step(20); level_in = 1'b0; step(40);
    level_in = 1'b1; tick();
    check("s4a_press", int'(press_strb), 1);
    check("s4a_no_click", int'(click_strb), 0);
    step(19); level_in = 1'b0; step(60);
    check("s4a_click_cnt", n_click - b_click, 0);
    check("s4a_dbl_cnt", n_dbl - b_dbl, 1);

    // Second rise one edge past window: click, then a fresh press
    snap();
    level_in = 1'b1; step(20); level_in = 1'b0; step(41);
    check("s4b_click", int'(click_strb), 1);
    check("s4b_no_press_yet", int'(press_strb), 0);
    level_in = 1'b1; tick();
    check("s4b_new_press", int'(press_strb), 1);
    check("s4b_held", int'(held), 1);
    step(19); level_in = 1'b0; step(60);
    check("s4b_click_cnt", n_click - b_click, 2);
    check("s4b_dbl_cnt", n_dbl - b_dbl, 0);

    // Second press held long: click and long together
    snap();
    level_in = 1'b1; step(20); level_in = 1'b0; step(10);
    level_in = 1'b1; step(120);
    check("s5_long_cnt", n_long - b_long, 1);
    check("s5_click_cnt", n_click - b_click, 1);
    check("s5_click_eq_long", t_click, t_long);
    check("s5_press_to_long", t_long - t_press, 99);
    level_in = 1'b0; step(60);
    check("s5_rel_cnt", n_rel - b_rel, 2);
    check("s5_dbl_cnt", n_dbl - b_dbl, 0);

    // Reset mid-press discards pending long press
    level_in = 1'b1; step(50);
    reset = 1'b1; tick();
    check("s6_reset_outs", outs(), 0);
    snap();
    level_in = 1'b0; tick(); reset = 1'b0; step(150);
    check("s6_no_strobes", (n_press - b_press) + (n_rel - b_rel) + (n_click - b_click)
                           + (n_long - b_long), 0);

    // Level high at reset release gives a press on the first enabled edge
    reset = 1'b1; level_in = 1'b1; step(2);
    reset = 1'b0; tick();
    check("s6_press_after_rst", int'(press_strb), 1);
    level_in = 1'b0; step(60);

    // Enable dropped mid-W2, then re-raised while level is high
    level_in = 1'b1; step(20); level_in = 1'b0; step(10);
    enable = 1'b0; tick();
    check("s7_dis_outs", outs(), 0);
    snap();
    level_in = 1'b1; step(5); enable = 1'b1; step(150);
    check("s7_no_press", n_press - b_press, 0);
    check("s7_held", int'(held), 0);
    check("s7_no_long_click", (n_long - b_long) + (n_click - b_click), 0);
    level_in = 1'b0; step(5);
    check("s7_no_release", n_rel - b_rel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
